// File: rtl/mfe_led7seg_pkg.sv
// mfe_led7seg_pkg: shared 7-segment constants (active-low), display geometry and a one-hot check helper
package mfe_led7seg_pkg;
  localparam int DIGITS = 8;
  localparam int WORD_W = 16;
  localparam logic [7:0] NUM_0 = 8'hC0, NUM_1 = 8'hF9, NUM_2 = 8'hA4, NUM_3 = 8'hB0;
  localparam logic [7:0] NUM_4 = 8'h99, NUM_5 = 8'h92, NUM_6 = 8'h82, NUM_7 = 8'hF8;
  localparam logic [7:0] NUM_8 = 8'h80, NUM_9 = 8'h90, NUM_A = 8'h88, NUM_B = 8'h83;
  localparam logic [7:0] NUM_C = 8'hC6, NUM_D = 8'hA1, NUM_E = 8'h86, NUM_F = 8'h8E;
  localparam logic [7:0] NUM_LINE = 8'hBF;
  function automatic logic not_onehot(input logic [DIGITS-1:0] s);
    return (s == '0) || ((s & (s - 1'b1)) != '0);
  endfunction
endpackage

// File: rtl/mfe_sync_edge.sv
// mfe_sync_edge: SYNC_STAGES-deep synchronizer with rising-edge detect; ports clk, rst, i_pin -> o_rise
module mfe_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_pin,
  output logic o_rise
);
  logic [SYNC_STAGES-1:0] r_sync;
  logic r_dly;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
      r_dly <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
      r_dly <= r_sync[SYNC_STAGES-1];
    end
  end
  assign o_rise = r_sync[SYNC_STAGES-1] & ~r_dly;
endmodule

// File: rtl/mfe_led7seg_74hc595_receiver.sv
// mfe_led7seg_74hc595_receiver: 74HC595-style serial receiver feeding an 8-digit display buffer; ports clk, rst, sclk, rclk, dio -> dat, vld, disp, sel_err, len_err; MFE_LED7SEG_RX_LEN_CHECK_EN enables the frame-length check
module mfe_led7seg_74hc595_receiver
  import mfe_led7seg_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sclk,
  input  logic                  rclk,
  input  logic                  dio,
  output logic [WORD_W-1:0]     dat,
  output logic                  vld,
  output logic [8*DIGITS-1:0]   disp,
  output logic                  sel_err,
  output logic                  len_err
);
  logic w_sclk_re, w_rclk_re;
  logic [SYNC_STAGES-1:0] r_dio_sync;
  logic [WORD_W-1:0] r_sr;
  mfe_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sclk (.clk(clk), .rst(rst), .i_pin(sclk), .o_rise(w_sclk_re));
  mfe_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_rclk (.clk(clk), .rst(rst), .i_pin(rclk), .o_rise(w_rclk_re));
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dio_sync <= '0;
      r_sr <= '0;
      dat <= '0;
      vld <= 1'b0;
      sel_err <= 1'b0;
      disp <= '1;
    end else begin
      r_dio_sync <= {r_dio_sync[SYNC_STAGES-2:0], dio};
      vld <= w_rclk_re;
      sel_err <= w_rclk_re && not_onehot(r_sr[DIGITS-1:0]);
      if (w_sclk_re) r_sr <= {r_sr[WORD_W-2:0], r_dio_sync[SYNC_STAGES-1]};
      // latch takes the pre-shift value when both edges coincide
      if (w_rclk_re) begin
        dat <= r_sr;
        for (int k = 0; k < DIGITS; k++)
          if (r_sr[k]) disp[8*k +: 8] <= r_sr[WORD_W-1:8];
      end
    end
  end
`ifdef MFE_LED7SEG_RX_LEN_CHECK_EN
  logic [4:0] r_cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      len_err <= 1'b0;
    end else begin
      len_err <= w_rclk_re && (r_cnt != 5'd16);
      // a shift in the latch cycle starts the next frame's count
      if (w_rclk_re) r_cnt <= {4'd0, w_sclk_re};
      else if (w_sclk_re) r_cnt <= (r_cnt == 5'd31) ? r_cnt : r_cnt + 5'd1;
    end
  end
`else
  assign len_err = 1'b0;
`endif
endmodule

// File: doc/mfe_led7seg_74hc595_receiver.md
MFE_LED7SEG_74HC595_RECEIVER -- requirements
Module: mfe_led7seg_74hc595_receiver

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops on each pin input; legal values are 2 or more.
REQ-002 SHALL have port clk  input  1  system clock; all logic is on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port sclk  input  1  asynchronous 74HC595 shift clock; its rising edge shifts in one bit.
REQ-005 SHALL have port rclk  input  1  asynchronous 74HC595 latch clock; its rising edge transfers the shift register to the storage register.
REQ-006 SHALL have port dio  input  1  asynchronous serial data.
REQ-007 SHALL have port dat  output  16  latched word: segment byte in [15:8] (active-low), one-hot digit select in [7:0].
REQ-008 SHALL have port vld  output  1  one-cycle pulse; dat is updated in the same cycle.
REQ-009 SHALL have port disp  output  64  display buffer; digit k occupies [8k+7:8k].
REQ-010 SHALL have port sel_err  output  1  one-cycle pulse when the latched select byte is not one-hot.
REQ-011 SHALL have port len_err  output  1  one-cycle pulse when a latch follows a bit count other than 16.

Function
REQ-012 SHALL pass sclk, rclk and dio through identical SYNC_STAGES-deep synchronizers.
REQ-013 SHALL detect rising edges from the last synchronizer stage against one extra delay flop.
REQ-014 SHALL, on each sclk rising edge, shift a 16-bit register left, with synchronized dio entering bit 0; the first bit sent therefore ends in bit 15.
REQ-015 SHALL, on an rclk rising edge, load dat and assert vld in the same cycle; latency from the first clk edge that samples rclk high is SYNC_STAGES+1 cycles.
REQ-016 SHALL, when sclk and rclk rising edges are detected in the same cycle, latch the pre-shift register value into dat, and the shift still occurs.
REQ-017 SHALL, in the vld cycle, write the segment byte to every disp byte whose select bit is 1, leaving all other bytes unchanged.
REQ-018 SHALL leave disp unchanged when the select byte is 0x00, and pulse sel_err with vld.
REQ-019 SHALL, when 2 or more select bits are set, update every selected byte and pulse sel_err with vld.
REQ-020 SHALL NOT clear the shift register on latch; bits keep shifting across rclk edges, as in the 74HC595.
REQ-021 SHALL require sclk and rclk high and low times of at least SYNC_STAGES+1 clk periods, and dio stable for 1 clk period either side of each sclk rise; behaviour outside these limits is not specified.

Reset
REQ-022 SHALL, while rst=1, drive dat=16'h0000, vld=0, sel_err=0, len_err=0, disp=64'hFFFF_FFFF_FFFF_FFFF (all segments off) and clear the shift register, synchronizers and bit counter.
REQ-023 SHALL, when rst rises mid-frame, discard any partial shift; the first latch after reset reflects only bits shifted after rst falls.
REQ-024 SHALL NOT detect an edge in the first cycle after reset release, even if a pin is already high.

Configuration
REQ-025 SHALL, with MFE_LED7SEG_RX_LEN_CHECK_EN defined, include a 5-bit bit counter:
- increments on each sclk edge and saturates at 31;
- is cleared on each rclk edge, with that cycle's shift, if any, counting as 1;
- pulses len_err with vld when the count before the latch is not 16.
REQ-026 SHALL, without MFE_LED7SEG_RX_LEN_CHECK_EN, omit the counter and tie len_err to 0.

Structure
REQ-027 SHALL take the active-low segment constants (NUM_0..NUM_F, NUM_LINE), DIGITS=8 and WORD_W=16 from the shared package mfe_led7seg_pkg.
REQ-028 SHALL implement the synchronizer plus rising-edge detect as sub-module mfe_sync_edge, instantiated once for sclk and once for rclk; dio uses the synchronizer path only.

Verification
REQ-029 SHALL verify: 16 bits of 16'hC001 shifted MSB-first then rclk -> vld pulse with dat=16'hC001, disp[7:0]=8'hC0, other bytes 8'hFF, sel_err=0.
REQ-030 SHALL verify: frames {NUM_0..NUM_7, one-hot 0x01..0x80} -> disp=64'hF882_9299_B0A4_F9C0, no errors.
REQ-031 SHALL verify: word 16'h9200 latched -> sel_err pulse, disp unchanged; word 16'h9203 -> bytes 0 and 1 become 8'h92, sel_err pulse.
REQ-032 SHALL verify: 15 bits then rclk with macro defined -> len_err pulse with vld; same stimulus without macro -> len_err stays 0.
REQ-033 SHALL verify: sclk and rclk rising together after 16 bits -> dat holds the pre-shift word, and the next latch reflects the extra bit.
REQ-034 SHALL verify: rst asserted after 8 bits, then a full 16-bit frame -> dat equals the new frame exactly, and disp returns to all-0xFF during reset.
